// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding and the frame/baud defaults.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 4167;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a level counter.
// The head entry is presented directly from storage registers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             push_en;
  logic             pop_en;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  always_comb begin
    level_d = level_q;
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO with ready/valid read side.
// Reports framing errors and dropped bytes as single-cycle pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          ser_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 armed_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic stop_sample;
  logic push_w;
  logic pop_w;
  logic fifo_full;
  logic fifo_empty;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], ser_rx};
  end

  assign rx_s        = sync_q[1];
  assign stop_sample = (state_q == STOP) && (cnt_q == BIT_END);
  assign push_w      = stop_sample && rx_s;
  assign pop_w       = !fifo_empty && rx_ready;

  // armed_q stays low after reset until the line has been seen idle-high.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_sample && !rx_s;
      overrun_q   <= push_w && fifo_full && !pop_w;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_END) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_END) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) state_q <= STOP;
            else                   bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .data_i  (shift_q),
    .data_o  (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rx_valid  = !fifo_empty;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 16 clocks per bit.
// Expected bytes are queued as frames are sent and matched against popped bytes.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       wbClk   = 1'b0;
  logic       wbRst   = 1'b1;
  logic       serRx   = 1'b1;
  logic       rxReady = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxBusy;
  logic       frameErr;
  logic       overrun;
  logic [2:0] fifoLevel;

  int testsRun    = 0;
  int testsFailed = 0;

  int validCycles   = 0;
  int frameErrCount = 0;
  int overrunCount  = 0;
  int bothCount     = 0;

  logic [7:0] obsQ[$];
  logic [7:0] expQ[$];
  int         obsIdx = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk_i   (wbClk),
    .wb_rst_i   (wbRst),
    .ser_rx     (serRx),
    .rx_data    (rxData),
    .rx_valid   (rxValid),
    .rx_ready   (rxReady),
    .rx_busy    (rxBusy),
    .frame_err  (frameErr),
    .overrun    (overrun),
    .fifo_level (fifoLevel)
  );

  always #5 wbClk = ~wbClk;

  // Observe the DUT mid-cycle; a byte is consumed whenever valid and ready are both high.
  always @(negedge wbClk) begin
    if (!wbRst) begin
      if (rxValid) validCycles++;
      if (frameErr) frameErrCount++;
      if (overrun) overrunCount++;
      if (frameErr && overrun) bothCount++;
      if (rxValid && rxReady) obsQ.push_back(rxData);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives start bit plus nBits data bits; a full frame also gets its stop bit and an idle gap.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int nBits);
    @(posedge wbClk); #1 serRx = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      repeat (CPB) @(posedge wbClk);
      #1 serRx = data[i];
    end
    if (nBits == 8) begin
      repeat (CPB) @(posedge wbClk);
      #1 serRx = stopBit;
      repeat (CPB) @(posedge wbClk);
      #1 serRx = 1'b1;
      repeat (20) @(posedge wbClk);
    end
  endtask

  task automatic drainCheck(input string tag, input int bound);
    int n;
    n = 0;
    while (((obsQ.size() - obsIdx) < expQ.size()) && (n < bound)) begin
      @(negedge wbClk);
      n++;
    end
    repeat (4) @(negedge wbClk);
    checkOutput({tag, " count"}, obsQ.size() - obsIdx, expQ.size());
    while ((expQ.size() > 0) && (obsIdx < obsQ.size())) begin
      checkOutput(tag, obsQ[obsIdx], expQ.pop_front());
      obsIdx++;
    end
    expQ.delete();
    obsIdx = obsQ.size();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " rx_valid"},   rxValid,   0);
    checkOutput({tag, " rx_data"},    rxData,    0);
    checkOutput({tag, " fifo_level"}, fifoLevel, 0);
    checkOutput({tag, " rx_busy"},    rxBusy,    0);
    checkOutput({tag, " frame_err"},  frameErr,  0);
    checkOutput({tag, " overrun"},    overrun,   0);
  endtask

  initial begin
    int vc0;
    int fe0;
    int ov0;
    logic busySeen;
    logic busyCleared;

    repeat (3) @(negedge wbClk);
    checkResetOutputs("reset");
    @(posedge wbClk); #1 wbRst = 1'b0;
    repeat (10) @(posedge wbClk);

    // Basic receive with consumer always ready.
    #1 rxReady = 1'b1;
    vc0 = validCycles; fe0 = frameErrCount; ov0 = overrunCount;
    expQ.push_back(8'h3D);
    applyStimulus(8'h3D, 1'b1, 8);
    drainCheck("basic byte", 50);
    checkOutput("basic valid cycles", validCycles - vc0, 1);
    checkOutput("basic frame_err", frameErrCount - fe0, 0);
    checkOutput("basic overrun", overrunCount - ov0, 0);

    // Fill past capacity with the consumer stalled.
    @(posedge wbClk); #1 rxReady = 1'b0;
    fe0 = frameErrCount; ov0 = overrunCount;
    expQ.push_back(8'h0F); expQ.push_back(8'h28);
    expQ.push_back(8'h7D); expQ.push_back(8'hED);
    applyStimulus(8'h0F, 1'b1, 8);
    applyStimulus(8'h28, 1'b1, 8);
    applyStimulus(8'h7D, 1'b1, 8);
    applyStimulus(8'hED, 1'b1, 8);
    @(negedge wbClk);
    checkOutput("fill level 4", fifoLevel, 4);
    applyStimulus(8'h6D, 1'b1, 8);
    @(negedge wbClk);
    checkOutput("fill level held", fifoLevel, 4);
    checkOutput("fill overrun pulses", overrunCount - ov0, 1);
    checkOutput("fill frame_err", frameErrCount - fe0, 0);
    @(posedge wbClk); #1 rxReady = 1'b1;
    drainCheck("fill order", 50);
    checkOutput("fill drained level", fifoLevel, 0);

    // Framing error followed by a good byte.
    vc0 = validCycles; fe0 = frameErrCount; ov0 = overrunCount;
    applyStimulus(8'hA5, 1'b0, 8);
    @(negedge wbClk);
    checkOutput("ferr pulses", frameErrCount - fe0, 1);
    checkOutput("ferr level", fifoLevel, 0);
    checkOutput("ferr no valid", validCycles - vc0, 0);
    expQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 8);
    drainCheck("ferr next byte", 50);
    checkOutput("ferr single pulse", frameErrCount - fe0, 1);
    checkOutput("ferr overrun", overrunCount - ov0, 0);

    // Short low glitch must be rejected at the start-bit midpoint.
    vc0 = validCycles; fe0 = frameErrCount; ov0 = overrunCount;
    @(posedge wbClk); #1 serRx = 1'b0;
    repeat (5) @(posedge wbClk);
    #1 serRx = 1'b1;
    @(negedge wbClk);
    busySeen = rxBusy;
    busyCleared = 1'b0;
    for (int i = 0; i < 10 && !busyCleared; i++) begin
      @(negedge wbClk);
      if (!rxBusy) busyCleared = 1'b1;
    end
    checkOutput("glitch busy seen", busySeen, 1);
    checkOutput("glitch busy clears", busyCleared, 1);
    repeat (30) @(negedge wbClk);
    checkOutput("glitch no valid", validCycles - vc0, 0);
    checkOutput("glitch level", fifoLevel, 0);
    checkOutput("glitch frame_err", frameErrCount - fe0, 0);
    checkOutput("glitch overrun", overrunCount - ov0, 0);

    // Reset in the middle of data bit 4 of 0x55.
    applyStimulus(8'h55, 1'b1, 5);
    repeat (8) @(posedge wbClk);
    #1 wbRst = 1'b1;
    serRx = 1'b1;
    @(negedge wbClk);
    checkResetOutputs("midframe reset");
    repeat (3) @(posedge wbClk);
    #1 wbRst = 1'b0;
    obsIdx = obsQ.size();
    fe0 = frameErrCount; ov0 = overrunCount;
    repeat (20) @(posedge wbClk);
    expQ.push_back(8'h33);
    applyStimulus(8'h33, 1'b1, 8);
    drainCheck("after reset byte", 50);
    checkOutput("after reset frame_err", frameErrCount - fe0, 0);
    checkOutput("after reset overrun", overrunCount - ov0, 0);

    // Push and pop together while full: ready rises exactly in the stop-sample cycle.
    @(posedge wbClk); #1 rxReady = 1'b0;
    ov0 = overrunCount;
    expQ.push_back(8'hC1); expQ.push_back(8'hC2);
    expQ.push_back(8'hC3); expQ.push_back(8'hC4);
    expQ.push_back(8'h99);
    applyStimulus(8'hC1, 1'b1, 8);
    applyStimulus(8'hC2, 1'b1, 8);
    applyStimulus(8'hC3, 1'b1, 8);
    applyStimulus(8'hC4, 1'b1, 8);
    fork
      applyStimulus(8'h99, 1'b1, 8);
      begin
        repeat (155) @(posedge wbClk);
        #1 rxReady = 1'b1;
        @(negedge wbClk);
        checkOutput("simul full before", fifoLevel, 4);
        @(negedge wbClk);
        checkOutput("simul level after", fifoLevel, 4);
        checkOutput("simul overrun", overrun, 0);
      end
    join
    drainCheck("simul order", 50);
    checkOutput("simul overrun pulses", overrunCount - ov0, 0);
    checkOutput("simul drained level", fifoLevel, 0);

    checkOutput("never both pulses", bothCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
